// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO window location, register
// offsets and status-register bit positions.
package mem_io_responder_pkg;

    localparam logic [17:0] IO_BASE     = 18'h30000;
    localparam logic [2:0]  IO_DATA_OFF = 3'h0;
    localparam logic [2:0]  IO_STAT_OFF = 3'h4;
    localparam logic [1:0]  IO_REGION   = IO_BASE[17:16];

    localparam int TX_FULL_BIT     = 0;
    localparam int RX_NONEMPTY_BIT = 1;

    function automatic logic [7:0] status_byte(input logic tx_full, input logic rx_nonempty);
        logic [7:0] s;
        s = 8'h00;
        s[TX_FULL_BIT]     = tx_full;
        s[RX_NONEMPTY_BIT] = rx_nonempty;
        return s;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO; DEPTH must be a power of two so pointers wrap
// naturally. The count is one bit wider than the pointers.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               din_i,
    output logic [7:0]               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign full_o    = (count_q == (PW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop_i && !empty_o;
    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    always_comb begin
        wr_ptr_d = push_ok_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: block RAM plus a TX/RX FIFO IO window at 0x30000.
// Optional macro HALT_PORT_EN adds a sticky halt_o set by writing 0x30004.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] bus_addr_i,
    input  logic        bus_wr_i,
    input  logic [7:0]  bus_wdata_i,
    output logic [7:0]  bus_rdata_o,
    output logic        bus_rdy_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o
`ifdef HALT_PORT_EN
    ,
    output logic        halt_o
`endif
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]       ram_q [2**ADDR_WIDTH];
    logic [7:0]       ram_rd_q;
    logic [7:0]       io_rdata_q, io_rdata_d;
    logic             src_ram_q, rd_data_prev_q, rdy_q;
    logic             is_io_s, rd_data_s, rd_stat_s, tx_push_s, tx_pop_s;
    logic             rx_push_s, rx_pop_s;
    logic [2:0]       off_s;
    logic             tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [7:0]       rx_dout_s;
    logic [TX_CW-1:0] tx_count_s;
    logic [RX_CW-1:0] rx_count_unused_s;
    logic [13:0]      addr_unused_s;

    assign addr_unused_s = bus_addr_i[31:18];
    assign is_io_s       = (bus_addr_i[17:16] == IO_REGION);
    assign off_s         = bus_addr_i[2:0];
    assign rd_data_s     = is_io_s && !bus_wr_i && (off_s == IO_DATA_OFF);
    assign rd_stat_s     = is_io_s && !bus_wr_i && (off_s == IO_STAT_OFF);
    assign tx_push_s     = is_io_s && bus_wr_i && (off_s == IO_DATA_OFF);
    assign tx_pop_s      = tx_valid_o && tx_ready_i;
    assign rx_push_s     = rx_valid_i && rx_ready_o;
    // Only the first cycle of a held data-port read consumes an RX byte.
    assign rx_pop_s      = rd_data_s && !rd_data_prev_q && !rx_empty_s;

    assign tx_valid_o  = !tx_empty_s;
    assign rx_ready_o  = !rx_full_s;
    assign bus_rdy_o   = rdy_q;
    assign bus_rdata_o = src_ram_q ? ram_rd_q : io_rdata_q;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (tx_push_s),
        .pop_i   (tx_pop_s),
        .din_i   (bus_wdata_i),
        .dout_o  (tx_data_o),
        .full_o  (tx_full_s),
        .empty_o (tx_empty_s),
        .count_o (tx_count_s)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (rx_push_s),
        .pop_i   (rx_pop_s),
        .din_i   (rx_data_i),
        .dout_o  (rx_dout_s),
        .full_o  (rx_full_s),
        .empty_o (rx_empty_s),
        .count_o (rx_count_unused_s)
    );

    // Read-first RAM: the registered read sees the byte before a same-cycle write.
    always_ff @(posedge clk_in) begin
        if (!is_io_s && bus_wr_i) begin
            ram_q[bus_addr_i[ADDR_WIDTH-1:0]] <= bus_wdata_i;
        end
        ram_rd_q <= ram_q[bus_addr_i[ADDR_WIDTH-1:0]];
    end

    always_comb begin
        io_rdata_d = 8'h00;
        if (rd_data_s) begin
            if (rd_data_prev_q) begin
                io_rdata_d = io_rdata_q;
            end else begin
                io_rdata_d = rx_empty_s ? 8'h00 : rx_dout_s;
            end
        end else if (rd_stat_s) begin
            io_rdata_d = status_byte(tx_full_s, !rx_empty_s);
        end else begin
            io_rdata_d = 8'h00;
        end
    end

    // Stall one write early so the write already in flight still fits.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            io_rdata_q     <= 8'h00;
            src_ram_q      <= 1'b0;
            rd_data_prev_q <= 1'b0;
            rdy_q          <= 1'b1;
        end else begin
            io_rdata_q     <= io_rdata_d;
            src_ram_q      <= !is_io_s;
            rd_data_prev_q <= rd_data_s;
            rdy_q          <= (tx_count_s < TX_CW'(TX_DEPTH - 1));
        end
    end

`ifdef HALT_PORT_EN
    logic halt_q;
    assign halt_o = halt_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            halt_q <= 1'b0;
        end else if (is_io_s && bus_wr_i && (off_s == IO_STAT_OFF)) begin
            halt_q <= 1'b1;
        end else begin
            halt_q <= halt_q;
        end
    end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX/RX FIFOs, flow control, reset.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] bus_addr_i;
    logic        bus_wr_i;
    logic [7:0]  bus_wdata_i;
    logic [7:0]  bus_rdata_o;
    logic        bus_rdy_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
`ifdef HALT_PORT_EN
    logic        halt_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    mem_io_responder dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .bus_addr_i  (bus_addr_i),
        .bus_wr_i    (bus_wr_i),
        .bus_wdata_i (bus_wdata_i),
        .bus_rdata_o (bus_rdata_o),
        .bus_rdy_o   (bus_rdy_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o)
`ifdef HALT_PORT_EN
        ,
        .halt_o      (halt_o)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
        bus_addr_i  = a;
        bus_wr_i    = w;
        bus_wdata_i = d;
    endtask

    initial begin
        rst_in = 1'b0;
        bus(32'h0, 1'b0, 8'h00);
        tx_ready_i = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        cyc(2);
        check("rst_rdata",    bus_rdata_o, 8'h00);
        check("rst_rdy",      {7'd0, bus_rdy_o}, 8'h01);
        check("rst_txvalid",  {7'd0, tx_valid_o}, 8'h00);
        check("rst_rxready",  {7'd0, rx_ready_o}, 8'h01);
`ifdef HALT_PORT_EN
        check("rst_halt",     {7'd0, halt_o}, 8'h00);
`endif
        rst_in = 1'b1;

        // RAM round trip and read-first behaviour
        bus(32'h00011, 1'b1, 8'h3C); cyc(1);
        bus(32'h00010, 1'b1, 8'hA5); cyc(1);
        bus(32'h00010, 1'b0, 8'h00); cyc(1);
        check("ram_rd_10", bus_rdata_o, 8'hA5);
        bus(32'h00011, 1'b0, 8'h00); cyc(1);
        check("ram_rd_11", bus_rdata_o, 8'h3C);
        bus(32'h00010, 1'b1, 8'h5A); cyc(1);
        check("ram_read_first", bus_rdata_o, 8'hA5);
        bus(32'h00010, 1'b0, 8'h00); cyc(1);
        check("ram_rd_new", bus_rdata_o, 8'h5A);
        bus(32'h30002, 1'b0, 8'h00); cyc(1);
        check("io_unmapped", bus_rdata_o, 8'h00);

        // TX path, in-order drain
        bus(32'h30000, 1'b1, 8'h41); cyc(1);
        bus(32'h30000, 1'b1, 8'h42); cyc(1);
        bus(32'h30000, 1'b1, 8'h43); cyc(1);
        bus(32'h00000, 1'b0, 8'h00);
        check("tx_valid_q", {7'd0, tx_valid_o}, 8'h01);
        tx_ready_i = 1'b1;
        check("tx_b0", tx_data_o, 8'h41); cyc(1);
        check("tx_b1", tx_data_o, 8'h42); cyc(1);
        check("tx_b2", tx_data_o, 8'h43); cyc(1);
        check("tx_valid_end", {7'd0, tx_valid_o}, 8'h00);
        tx_ready_i = 1'b0;

        // TX backpressure
        for (int i = 0; i < 15; i++) begin
            bus(32'h30000, 1'b1, 8'(i + 8'h60)); cyc(1);
        end
        bus(32'h00000, 1'b0, 8'h00); cyc(1);
        check("tx_rdy_low", {7'd0, bus_rdy_o}, 8'h00);
        bus(32'h30000, 1'b1, 8'hFF); cyc(1);
        bus(32'h30004, 1'b0, 8'h00); cyc(1);
        check("tx_stat_full", bus_rdata_o, 8'h01);
        check("tx_head_bp", tx_data_o, 8'h60);
        bus(32'h00000, 1'b0, 8'h00);
        tx_ready_i = 1'b1;
        cyc(20);
        check("tx_rdy_back", {7'd0, bus_rdy_o}, 8'h01);
        check("tx_drained", {7'd0, tx_valid_o}, 8'h00);
        tx_ready_i = 1'b0;

        // RX path with held-address single pop
        rx_valid_i = 1'b1; rx_data_i = 8'h10; cyc(1);
        rx_data_i = 8'h20; cyc(1);
        rx_valid_i = 1'b0;
        bus(32'h30004, 1'b0, 8'h00); cyc(1);
        check("rx_stat", bus_rdata_o, 8'h02);
        bus(32'h30000, 1'b0, 8'h00);
        cyc(1); check("rx_hold0", bus_rdata_o, 8'h10);
        cyc(1); check("rx_hold1", bus_rdata_o, 8'h10);
        cyc(1); check("rx_hold2", bus_rdata_o, 8'h10);
        bus(32'h30004, 1'b0, 8'h00); cyc(1);
        check("rx_stat_one_left", bus_rdata_o, 8'h02);
        bus(32'h30000, 1'b0, 8'h00); cyc(1);
        check("rx_second", bus_rdata_o, 8'h20);
        bus(32'h00000, 1'b0, 8'h00); cyc(1);
        bus(32'h30000, 1'b0, 8'h00); cyc(1);
        check("rx_empty_rd", bus_rdata_o, 8'h00);
        bus(32'h30004, 1'b0, 8'h00); cyc(1);
        check("rx_stat_empty", bus_rdata_o, 8'h00);

        // RX full: 16 accepted, 17th refused
        rx_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data_i = 8'(8'h80 + i); cyc(1);
        end
        check("rx_full_ready", {7'd0, rx_ready_o}, 8'h00);
        rx_data_i = 8'hEE; cyc(1);
        rx_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus(32'h30000, 1'b0, 8'h00); cyc(1);
            check("rx_full_data", bus_rdata_o, 8'(8'h80 + i));
            bus(32'h00000, 1'b0, 8'h00); cyc(1);
        end
        bus(32'h30000, 1'b0, 8'h00); cyc(1);
        check("rx_after_full", bus_rdata_o, 8'h00);

        // Reset mid-traffic with a RAM read in flight
        for (int i = 0; i < 5; i++) begin
            bus(32'h30000, 1'b1, 8'(i)); cyc(1);
        end
        bus(32'h00010, 1'b0, 8'h00);
        rst_in = 1'b0; cyc(1);
        check("mid_rst_txvalid", {7'd0, tx_valid_o}, 8'h00);
        check("mid_rst_rdy",     {7'd0, bus_rdy_o}, 8'h01);
        check("mid_rst_rdata",   bus_rdata_o, 8'h00);
        rst_in = 1'b1;

`ifdef HALT_PORT_EN
        bus(32'h30004, 1'b1, 8'h00); cyc(1);
        bus(32'h00000, 1'b0, 8'h00);
        check("halt_set", {7'd0, halt_o}, 8'h01);
        cyc(2);
        check("halt_sticky", {7'd0, halt_o}, 8'h01);
        rst_in = 1'b0; cyc(1);
        check("halt_rst", {7'd0, halt_o}, 8'h00);
        rst_in = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus: address, write strobe, 8-bit write data, 8-bit read data.
- Serves two regions:
  - Block RAM, 2^ADDR_WIDTH bytes.
  - Memory-mapped IO at 0x30000, backed by TX and RX byte FIFOs toward a UART/host link.
- Drives the CPU's rdy input to stall the core when the TX FIFO cannot take another byte.

Parameters:
ADDR_WIDTH, 17, RAM address bits; RAM holds 2^ADDR_WIDTH bytes.
TX_DEPTH, 16, TX FIFO depth in bytes; power of two, >= 4.
RX_DEPTH, 16, RX FIFO depth in bytes; power of two, >= 4.

Ports:
clk_in  input  1  system clock.
rst_in  input  1  synchronous reset, active-low.
bus_addr_i  input  32  CPU address; bits 17:0 decoded.
bus_wr_i  input  1  1 = write, 0 = read.
bus_wdata_i  input  8  CPU write data.
bus_rdata_o  output  8  read data, valid one cycle after its address.
bus_rdy_o  output  1  CPU ready; low pauses the CPU.
tx_data_o  output  8  TX FIFO head byte.
tx_valid_o  output  1  TX FIFO non-empty.
tx_ready_i  input  1  sink accepts tx_data_o this cycle.
rx_data_i  input  8  incoming byte.
rx_valid_i  input  1  rx_data_i valid.
rx_ready_o  output  1  RX FIFO not full.

Behaviour:
- Reset (rst_in=0 at posedge): both FIFOs empty, bus_rdata_o=0, bus_rdy_o=1, tx_valid_o=0, rx_ready_o=1, pop-edge tracker cleared. RAM contents are not reset.
- Decode:
  - bus_addr_i[17:16]==2'b11 selects IO.
  - Any other address selects RAM at bus_addr_i[ADDR_WIDTH-1:0].
- RAM:
  - Write on posedge when bus_wr_i=1 in the RAM region.
  - Read is registered: bus_rdata_o at edge N+1 equals RAM[addr] presented at edge N.
  - Read-after-write to the same address returns the old byte (read-first).
- IO map (offset = bus_addr_i[2:0]; full address 0x30000+offset):
  - 0x30000 write: push bus_wdata_i into TX FIFO.
  - 0x30000 read: pop RX FIFO and return its head; return 0x00 with no pop if empty.
  - 0x30004 read: {6'b0, rx_nonempty, tx_full}.
  - 0x30004 write: ignored, unless HALT_PORT_EN is defined.
  - All other IO offsets read 0x00; writes to them are ignored.
- RX pop edge detect: pop only on the first cycle of a run of consecutive read cycles at 0x30000. A tracker register records "previous cycle was a read of 0x30000". Repeated address hold therefore pops exactly once.
- TX flow control:
  - bus_rdy_o is registered: 0 when TX count >= TX_DEPTH-1, else 1. The single write in flight when it drops therefore always fits.
  - A push while the FIFO is full is dropped.
- TX drain: pop when tx_valid_o & tx_ready_i. Simultaneous push and pop in one cycle: count unchanged, both operations take effect.
- RX fill: push when rx_valid_i & rx_ready_o. Simultaneous push and pop: count unchanged.
- Pointer wrap: modulo depth. Count is one bit wider than the pointers so full and empty are distinguishable.
- Reset mid-operation: FIFO contents are discarded; any read in flight returns 0x00 on the next cycle.

Optional Feature:
HALT_PORT_EN
- Defined: adds output port halt_o (1 bit). A write of any value to 0x30004 sets halt_o=1, sticky until reset. halt_o resets to 0. Used by the simulation bench to end a program.
- Undefined: halt_o does not exist; writes to 0x30004 are ignored.

Decomposition:
- Shared package holds:
  - IO_BASE = 18'h30000, IO_DATA_OFF = 3'h0, IO_STAT_OFF = 3'h4.
  - Region-select constant 2'b11.
  - Status bit indices: TX_FULL_BIT = 0, RX_NONEMPTY_BIT = 1.
- Sub-module byte_fifo, parameterized on DEPTH, with ports push/pop/din/dout/full/empty/count. Instantiated twice (TX, RX).
- The top level contains the RAM, decode, read mux, pop-edge tracker and ready logic.

Test Plan:
- RAM round trip: write 0xA5 to 0x00010, then read 0x00010 -> bus_rdata_o=0xA5 exactly one cycle after the read address. Read 0x00011 (never written after preload 0x3C) -> 0x3C.
- TX path: tx_ready_i=0; write 0x41, 0x42, 0x43 to 0x30000; then tx_ready_i=1 -> tx_data_o shows 0x41, 0x42, 0x43 in order; tx_valid_o falls after the third handshake.
- TX backpressure (TX_DEPTH=16, tx_ready_i=0): write 15 bytes -> bus_rdy_o=0 the cycle after the 15th push. 16th write still lands; status at 0x30004 reads 0x01. Assert tx_ready_i -> bus_rdy_o returns to 1.
- RX path: drive bytes 0x10, 0x20; read 0x30004 -> 0x02. Hold address 0x30000 for 3 cycles -> returns 0x10 with a single pop. Next separate read -> 0x20. Third read -> 0x00, no underflow.
- RX full: push 16 bytes with no reads -> rx_ready_o=0. A 17th rx_valid_i pulse is not accepted; count stays 16.
- Reset mid-traffic: 5 bytes queued in TX, rst_in=0 for one cycle -> tx_valid_o=0, bus_rdy_o=1, bus_rdata_o=0x00. With HALT_PORT_EN: write 0x30004 -> halt_o=1 until reset.
